pitch_unit_framer: RTL

Transmit-side counterpart of the BATS PITCH parser: accepts PITCH messages as 64-bit little-endian words with byte enables and emits a complete Sequenced Unit (8-byte header plus back-to-back messages) on the same 64-bit word/byte-enable format the parser consumes. It sits between a message source (replay engine or order-book test generator) and the UDP payload path, and its output can be looped directly into the parser for closed-loop verification.

---
 rtl/pitch_unit_framer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/pitch_unit_framer.sv
`default_nettype none
// ============================================================================
// Module   : pitch_unit_framer
// Brief    : Packs PITCH messages behind an 8-byte Sequenced Unit header onto
//            a 64-bit little-endian word / byte-enable stream.
// Revision : 1.0 - initial release
// ============================================================================
module pitch_unit_framer #(
  parameter logic [31:0] SEQ_INIT = 32'd1
) (
  input  logic        Clk40,
  input  logic        reset_n,
  input  logic        seq_load,
  input  logic [31:0] seq_value,
  input  logic        unit_valid,
  output logic        unit_ready,
  input  logic [15:0] unit_len,
  input  logic [7:0]  unit_count,
  input  logic [7:0]  unit_id,
  input  logic        data_valid,
  output logic        ready_for_msg_input,
  input  logic [7:0]  byte_enables,
  input  logic [63:0] bytes,
  input  logic        msg_last,
  output logic        out_valid,
  input  logic        ready_for_udp_output,
  output logic [7:0]  out_byte_enables,
  output logic [63:0] out_bytes,
  output logic        out_last,
  output logic        len_error,
  output logic [31:0] seq_next
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HDR   = 2'd1,
    S_BODY  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  function automatic logic [3:0] be_count(input logic [7:0] be);
    be_count = 4'd0;
    for (int i = 0; i < 8; i++) be_count = be_count + {3'd0, be[i]};
  endfunction

  function automatic logic [7:0] be_mask(input logic [3:0] k);
    be_mask = 8'd0;
    for (int i = 0; i < 8; i++) be_mask[i] = (4'(i) < k);
  endfunction

  function automatic logic [63:0] mask_bytes(input logic [63:0] b, input logic [7:0] be);
    mask_bytes = 64'd0;
    for (int i = 0; i < 8; i++) mask_bytes[8*i +: 8] = b[8*i +: 8] & {8{be[i]}};
  endfunction

  state_t      r_state, w_state_nxt;
  logic        r_out_valid, w_out_valid_nxt;
  logic        r_out_last, w_out_last_nxt;
  logic        r_len_err, w_len_err_nxt;
  logic [63:0] r_out_bytes, w_out_bytes_nxt;
  logic [7:0]  r_out_be, w_out_be_nxt;
  logic [55:0] r_res, w_res_nxt;
  logic [2:0]  r_res_cnt, w_res_cnt_nxt;
  logic [7:0]  r_msg_cnt, w_msg_cnt_nxt;
  logic [16:0] r_byte_cnt, w_byte_cnt_nxt;
  logic [15:0] r_len, w_len_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_seq, w_seq_nxt;

  logic        w_out_fire, w_unit_acc, w_in_acc, w_seq_ld, w_closing;
  logic [31:0] w_seq_base;
  logic [63:0] w_in_masked;
  logic [3:0]  w_n, w_sum;
  logic [119:0] w_comb;
  logic [16:0] w_byte_total;

  assign w_out_fire          = r_out_valid && ready_for_udp_output;
  assign unit_ready          = reset_n && (r_state == S_IDLE) && !r_out_valid;
  assign ready_for_msg_input = (r_state == S_BODY) && (!r_out_valid || ready_for_udp_output);
  assign w_unit_acc          = unit_valid && unit_ready;
  assign w_in_acc            = data_valid && ready_for_msg_input;
  assign w_seq_ld            = seq_load && (r_state == S_IDLE);
  assign w_seq_base          = w_seq_ld ? seq_value : r_seq;

  // Residue occupies the low bytes; the new word lands directly above it.
  assign w_n          = be_count(byte_enables);
  assign w_in_masked  = mask_bytes(bytes, byte_enables);
  assign w_sum        = {1'b0, r_res_cnt} + w_n;
  assign w_comb       = ({56'd0, w_in_masked} << {r_res_cnt, 3'b000}) | {64'd0, r_res};
  assign w_byte_total = r_byte_cnt + {13'd0, w_n};
  assign w_closing    = msg_last && (8'(r_msg_cnt + 8'd1) == r_cnt);

  assign w_seq_nxt = w_seq_base + ((w_out_fire && r_out_last) ? {24'd0, r_cnt} : 32'd0);

  always_comb begin
    w_state_nxt     = r_state;
    w_out_valid_nxt = r_out_valid && !w_out_fire;
    w_out_bytes_nxt = r_out_bytes;
    w_out_be_nxt    = r_out_be;
    w_out_last_nxt  = r_out_last;
    w_len_err_nxt   = 1'b0;
    w_res_nxt       = r_res;
    w_res_cnt_nxt   = r_res_cnt;
    w_msg_cnt_nxt   = r_msg_cnt;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_len_nxt       = r_len;
    w_cnt_nxt       = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_unit_acc) begin
          w_len_nxt       = unit_len;
          w_cnt_nxt       = unit_count;
          w_out_valid_nxt = 1'b1;
          w_out_bytes_nxt = {w_seq_base, unit_id, unit_count, 16'(unit_len + 16'd8)};
          w_out_be_nxt    = 8'hFF;
          w_out_last_nxt  = (unit_count == 8'd0);
          w_len_err_nxt   = (unit_count == 8'd0) && (unit_len != 16'd0);
          w_res_nxt       = 56'd0;
          w_res_cnt_nxt   = 3'd0;
          w_msg_cnt_nxt   = 8'd0;
          w_byte_cnt_nxt  = 17'd0;
          w_state_nxt     = S_HDR;
        end
      end
      S_HDR: begin
        if (w_out_fire) w_state_nxt = (r_cnt == 8'd0) ? S_IDLE : S_BODY;
      end
      S_BODY: begin
        if (w_in_acc) begin
          w_byte_cnt_nxt = w_byte_total;
          w_msg_cnt_nxt  = r_msg_cnt + {7'd0, msg_last};
          if (w_closing && (w_sum <= 4'd8)) begin
            w_out_valid_nxt = 1'b1;
            w_out_bytes_nxt = w_comb[63:0];
            w_out_be_nxt    = be_mask(w_sum);
            w_out_last_nxt  = 1'b1;
            w_len_err_nxt   = (w_byte_total != {1'b0, r_len});
            w_res_nxt       = 56'd0;
            w_res_cnt_nxt   = 3'd0;
            w_state_nxt     = S_IDLE;
          end else if (w_sum >= 4'd8) begin
            w_out_valid_nxt = 1'b1;
            w_out_bytes_nxt = w_comb[63:0];
            w_out_be_nxt    = 8'hFF;
            w_out_last_nxt  = 1'b0;
            w_res_nxt       = w_comb[119:64];
            w_res_cnt_nxt   = w_sum[2:0];
            if (w_closing) w_state_nxt = S_FLUSH;
          end else begin
            w_res_nxt     = w_comb[55:0];
            w_res_cnt_nxt = w_sum[2:0];
          end
        end
      end
      S_FLUSH: begin
        if (!r_out_valid || ready_for_udp_output) begin
          w_out_valid_nxt = 1'b1;
          w_out_bytes_nxt = {8'd0, r_res};
          w_out_be_nxt    = be_mask({1'b0, r_res_cnt});
          w_out_last_nxt  = 1'b1;
          w_len_err_nxt   = (r_byte_cnt != {1'b0, r_len});
          w_res_nxt       = 56'd0;
          w_res_cnt_nxt   = 3'd0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk40 or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_out_bytes <= 64'd0;
      r_out_be    <= 8'd0;
      r_out_last  <= 1'b0;
      r_len_err   <= 1'b0;
      r_res       <= 56'd0;
      r_res_cnt   <= 3'd0;
      r_msg_cnt   <= 8'd0;
      r_byte_cnt  <= 17'd0;
      r_len       <= 16'd0;
      r_cnt       <= 8'd0;
      r_seq       <= SEQ_INIT;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_bytes <= w_out_bytes_nxt;
      r_out_be    <= w_out_be_nxt;
      r_out_last  <= w_out_last_nxt;
      r_len_err   <= w_len_err_nxt;
      r_res       <= w_res_nxt;
      r_res_cnt   <= w_res_cnt_nxt;
      r_msg_cnt   <= w_msg_cnt_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_len       <= w_len_nxt;
      r_cnt       <= w_cnt_nxt;
      r_seq       <= w_seq_nxt;
    end
  end

  assign out_valid        = r_out_valid;
  assign out_bytes        = r_out_bytes;
  assign out_byte_enables = r_out_be;
  assign out_last         = r_out_last;
  assign len_error        = r_len_err;
  assign seq_next         = r_seq;

endmodule
`default_nettype wire
